// File: rtl/weight_pack_reg_pkg.sv
// Shared definitions for the weight re-packer: bitwidth encodings, lane width,
// beat count and replica-compare helpers.
package weight_pack_reg_pkg;

  localparam int LANE_W = 8;
  localparam int DATA_W = 4 * LANE_W;

  localparam logic [1:0] BW_8B = 2'b00;
  localparam logic [1:0] BW_4B = 2'b01;
  localparam logic [1:0] BW_2B = 2'b10;

  // 2'b11 is treated as 2-bit, matching the unpacker.
  function automatic logic [2:0] beats_per_word(input logic [1:0] bw);
    logic [2:0] n;
    case (bw)
      BW_8B:   n = 3'd1;
      BW_4B:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic replica_mismatch(input logic [1:0] bw, input logic [DATA_W-1:0] a);
    logic m;
    case (bw)
      BW_8B:   m = 1'b0;
      BW_4B:   m = (a[15:8] != a[7:0]) || (a[31:24] != a[23:16]);
      default: m = (a[15:8] != a[7:0]) || (a[23:16] != a[7:0]) || (a[31:24] != a[7:0]);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/weight_pack_lane_sel.sv
// Combinational byte-slot extractor: picks the meaningful byte(s) of a
// replicated lane word and places them in the slot(s) owned by this beat.
module weight_pack_lane_sel #(
  parameter int LANE_W = 8
) (
  input  logic [1:0]          bw,
  input  logic [1:0]          beat_idx,
  input  logic [4*LANE_W-1:0] in_data,
  output logic [3:0]          byte_en,
  output logic [4*LANE_W-1:0] slot_data
);
  import weight_pack_reg_pkg::*;

  logic [LANE_W-1:0] lo_s;
  logic [LANE_W-1:0] hi_s;

  assign lo_s = in_data[LANE_W-1:0];
  assign hi_s = in_data[3*LANE_W-1:2*LANE_W];

  // slot selection by bitwidth and beat position
  always_comb begin
    byte_en   = 4'b0000;
    slot_data = {(4*LANE_W){1'b0}};
    case (bw)
      BW_8B: begin
        byte_en   = 4'b1111;
        slot_data = in_data;
      end
      BW_4B: begin
        if (beat_idx[0] == 1'b0) begin
          byte_en   = 4'b0011;
          slot_data = {{(2*LANE_W){1'b0}}, hi_s, lo_s};
        end else begin
          byte_en   = 4'b1100;
          slot_data = {hi_s, lo_s, {(2*LANE_W){1'b0}}};
        end
      end
      default: begin
        byte_en = 4'b0001 << beat_idx;
        for (int i = 0; i < 4; i++) begin
          slot_data[i*LANE_W +: LANE_W] = byte_en[i] ? lo_s : {LANE_W{1'b0}};
        end
      end
    endcase
  end

endmodule

// File: rtl/weight_pack_reg.sv
// Re-packs replicated lane words into dense 32-bit buffer words (1/2/4 beats).
// Optional replica-consistency checker: define WEIGHT_PACK_REPLICA_CHECK_EN.
module weight_pack_reg #(
  parameter int LANE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          input_bitwidth,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*LANE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*LANE_W-1:0] out_data,
  output logic [1:0]          beat_idx,
  output logic                replica_err
);
  import weight_pack_reg_pkg::*;

  localparam int DW = 4 * LANE_W;

  logic [1:0]    bw_q_r;
  logic [1:0]    beat_idx_r;
  logic [DW-1:0] asm_r;
  logic [DW-1:0] out_data_r;
  logic          out_valid_r;

  logic [1:0]    bw_eff_s;
  logic [3:0]    byte_en_s;
  logic [DW-1:0] slot_data_s;
  logic [DW-1:0] en_mask_s;
  logic [DW-1:0] merged_s;
  logic          last_s;
  logic          accept_s;
  logic          complete_s;

  // The first beat of a word uses the live bitwidth; later beats use the latched one.
  assign bw_eff_s   = (beat_idx_r == 2'd0) ? input_bitwidth : bw_q_r;
  assign last_s     = ({1'b0, beat_idx_r} == (beats_per_word(bw_eff_s) - 3'd1));
  assign in_ready   = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready && !clear;
  assign complete_s = accept_s && last_s;

  weight_pack_lane_sel #(.LANE_W(LANE_W)) u_lane_sel (
    .bw        (bw_eff_s),
    .beat_idx  (beat_idx_r),
    .in_data   (in_data),
    .byte_en   (byte_en_s),
    .slot_data (slot_data_s)
  );

  // expand byte enables into a bit mask for the merge
  always_comb begin
    en_mask_s = {DW{1'b0}};
    for (int i = 0; i < 4; i++) begin
      en_mask_s[i*LANE_W +: LANE_W] = {LANE_W{byte_en_s[i]}};
    end
  end

  assign merged_s = (asm_r & ~en_mask_s) | slot_data_s;

  // beat counter, assembly register and output word register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bw_q_r      <= BW_8B;
      beat_idx_r  <= 2'd0;
      asm_r       <= {DW{1'b0}};
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (clear) begin
        beat_idx_r <= 2'd0;
        asm_r      <= {DW{1'b0}};
      end else if (accept_s) begin
        if (beat_idx_r == 2'd0) begin
          bw_q_r <= input_bitwidth;
        end else begin
          bw_q_r <= bw_q_r;
        end
        if (last_s) begin
          beat_idx_r <= 2'd0;
          asm_r      <= {DW{1'b0}};
        end else begin
          beat_idx_r <= beat_idx_r + 2'd1;
          asm_r      <= merged_s;
        end
      end else begin
        beat_idx_r <= beat_idx_r;
      end
      if (complete_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= merged_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign beat_idx  = beat_idx_r;

`ifdef WEIGHT_PACK_REPLICA_CHECK_EN
  logic replica_err_r;

  // sticky replica-mismatch flag; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      replica_err_r <= 1'b0;
    end else if (accept_s && replica_mismatch(bw_eff_s, in_data)) begin
      replica_err_r <= 1'b1;
    end else begin
      replica_err_r <= replica_err_r;
    end
  end

  assign replica_err = replica_err_r;
`else
  assign replica_err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_pack_reg.sv
// Scoreboard bench for weight_pack_reg: inputs change on the falling edge,
// outputs are compared on the falling edge against queued expected words.
module tb_weight_pack_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  input_bitwidth;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  beat_idx;
  logic        replica_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic        exp_err;

  weight_pack_reg #(.LANE_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .input_bitwidth (input_bitwidth),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .beat_idx       (beat_idx),
    .replica_err    (replica_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 32'h0;
    input_bitwidth = 2'b00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL reset_beat_idx: got %0d expected 0", beat_idx); end
    checks++; if (replica_err !== 1'b0) begin errors++; $display("FAIL reset_replica_err: got %b expected 0", replica_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_8bit();
    @(negedge clk);
    input_bitwidth = 2'b00; out_ready = 1'b1; in_data = 32'hA1B2C3D4; in_valid = 1'b1;
    exp_q.push_back(32'hA1B2C3D4);
    @(negedge clk);
    in_valid = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL 8b_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== exp_w) begin errors++; $display("FAIL 8b_data: got %h expected %h", out_data, exp_w); end
    checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL 8b_beat_idx: got %0d expected 0", beat_idx); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL 8b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_4bit();
    @(negedge clk);
    input_bitwidth = 2'b01; out_ready = 1'b1; in_data = 32'h22221111; in_valid = 1'b1;
    exp_q.push_back(32'h44332211);
    @(negedge clk);
    checks++; if (beat_idx !== 2'd1) begin errors++; $display("FAIL 4b_mid_beat_idx: got %0d expected 1", beat_idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL 4b_mid_valid: got %b expected 0", out_valid); end
    in_data = 32'h44443333;
    @(negedge clk);
    in_valid = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL 4b_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== exp_w) begin errors++; $display("FAIL 4b_data: got %h expected %h", out_data, exp_w); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL 4b_one_cycle: got %b expected 0", out_valid); end
  endtask

  task automatic test_2bit_backpressure();
    logic [31:0] beats [4];
    beats[0] = 32'h11111111; beats[1] = 32'h22222222;
    beats[2] = 32'h33333333; beats[3] = 32'h44444444;
    @(negedge clk);
    input_bitwidth = 2'b10; out_ready = 1'b0;
    exp_q.push_back(32'h44332211);
    for (int k = 0; k < 4; k++) begin
      in_data = beats[k]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_data = 32'h55555555;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL 2b_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL 2b_data: got %h expected %h", out_data, exp_q[0]); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL 2b_in_ready_low: got %b expected 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_data !== exp_q[0] || out_valid !== 1'b1) begin errors++; $display("FAIL 2b_hold: got %h/%b expected %h/1", out_data, out_valid, exp_q[0]); end
      checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL 2b_no_accept: got beat_idx %0d expected 0", beat_idx); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL 2b_in_ready_high: got %b expected 1", in_ready); end
    exp_w = exp_q.pop_front();
    checks++; if (out_data !== exp_w) begin errors++; $display("FAIL 2b_drain_data: got %h expected %h", out_data, exp_w); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL 2b_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_bw_change_clear();
    @(negedge clk);
    out_ready = 1'b1; input_bitwidth = 2'b01; in_data = 32'h22221111; in_valid = 1'b1;
    exp_q.push_back(32'h44332211);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bwchg_early: got %b expected 0", out_valid); end
    input_bitwidth = 2'b00; in_data = 32'h44443333;
    @(negedge clk);
    in_valid = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin errors++; $display("FAIL bwchg_data: got %h/%b expected %h/1", out_data, out_valid, exp_w); end
    @(negedge clk);
    input_bitwidth = 2'b01; in_data = 32'h22221111; in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b1; in_data = 32'h44443333;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL clear_beat_idx: got %0d expected 0", beat_idx); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_valid2: got %b expected 0", out_valid); end
    input_bitwidth = 2'b01; in_data = 32'h00000000; in_valid = 1'b1;
    exp_q.push_back(32'h88770000);
    @(negedge clk);
    in_data = 32'h88887777;
    @(negedge clk);
    in_valid = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin errors++; $display("FAIL post_clear_data: got %h/%b expected %h/1", out_data, out_valid, exp_w); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    @(negedge clk);
    input_bitwidth = 2'b00; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        exp_w = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin errors++; $display("FAIL b2b_word%0d: got %h/%b expected %h/1", i - 1, out_data, out_valid, exp_w); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready); end
      end
      d = $urandom;
      in_data = d; in_valid = 1'b1;
      exp_q.push_back(d);
      @(negedge clk);
    end
    in_valid = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin errors++; $display("FAIL b2b_last: got %h/%b expected %h/1", out_data, out_valid, exp_w); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_replica();
`ifdef WEIGHT_PACK_REPLICA_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++; if (replica_err !== 1'b0) begin errors++; $display("FAIL replica_clean: got %b expected 0", replica_err); end
    @(negedge clk);
    out_ready = 1'b1; input_bitwidth = 2'b01; in_data = 32'h22231111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (replica_err !== exp_err) begin errors++; $display("FAIL replica_set: got %b expected %b", replica_err, exp_err); end
    checks++; if (beat_idx !== 2'd1) begin errors++; $display("FAIL replica_beat_idx: got %0d expected 1", beat_idx); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL replica_clear_idx: got %0d expected 0", beat_idx); end
    @(negedge clk);
    checks++; if (replica_err !== exp_err) begin errors++; $display("FAIL replica_sticky: got %b expected %b", replica_err, exp_err); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b1; input_bitwidth = 2'b10; in_data = 32'h55555555; in_valid = 1'b1;
    @(negedge clk);
    in_data = 32'h66666666;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (beat_idx !== 2'd2) begin errors++; $display("FAIL arst_pre_idx: got %0d expected 2", beat_idx); end
    #2 reset = 1'b1;
    #1;
    checks++; if (beat_idx !== 2'd0) begin errors++; $display("FAIL arst_idx: got %0d expected 0", beat_idx); end
    checks++; if (replica_err !== 1'b0) begin errors++; $display("FAIL arst_replica_err: got %b expected 0", replica_err); end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b0; input_bitwidth = 2'b00; in_data = 32'h12345678; in_valid = 1'b1;
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    in_valid = 1'b0;
    exp_w = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin errors++; $display("FAIL arst_pending: got %h/%b expected %h/1", out_data, out_valid, exp_w); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL arst_out: got %h/%b expected 0/0", out_data, out_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8bit();
    test_4bit();
    test_2bit_backpressure();
    test_bw_change_clear();
    test_back_to_back();
    test_replica();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
